// File: rtl/display_pkg.sv
// Shared constants for the 640x400 micro-display raster: default frame timing,
// the Y/Cb/Cr pixel layout and the 16-entry colour palette.
package display_pkg;

    localparam int HC_W   = 10;
    localparam int VC_W   = 9;
    localparam int ADDR_W = 18;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    localparam timing_t DEFAULT_TIMING = '{
        h_active: 640, h_fp: 16, h_sync: 64, h_bp: 80,
        v_active: 400, v_fp: 4,  v_sync: 6,  v_bp: 40
    };

    typedef struct packed {
        logic [3:0] y;
        logic [2:0] cb;
        logic [2:0] cr;
    } pixel_t;

    localparam pixel_t BLACK = '{y: 4'd0, cb: 3'd4, cr: 3'd4};

    // Entries 5..15 form a grey ramp whose luma equals the index.
    localparam pixel_t PALETTE [16] = '{
        '{4'd0,  3'd4, 3'd4},
        '{4'd15, 3'd4, 3'd4},
        '{4'd5,  3'd3, 3'd7},
        '{4'd9,  3'd1, 3'd1},
        '{4'd2,  3'd7, 3'd3},
        '{4'd5,  3'd4, 3'd4},
        '{4'd6,  3'd4, 3'd4},
        '{4'd7,  3'd4, 3'd4},
        '{4'd8,  3'd4, 3'd4},
        '{4'd9,  3'd4, 3'd4},
        '{4'd10, 3'd4, 3'd4},
        '{4'd11, 3'd4, 3'd4},
        '{4'd12, 3'd4, 3'd4},
        '{4'd13, 3'd4, 3'd4},
        '{4'd14, 3'd4, 3'd4},
        '{4'd15, 3'd4, 3'd4}
    };

endpackage

// File: rtl/display_timing.sv
// Raster counters for the display: walks hc/vc over the frame and registers the
// frame-buffer address together with the sync and active flags of that pixel.
module display_timing
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEFAULT_TIMING.h_active,
    parameter int H_FP     = DEFAULT_TIMING.h_fp,
    parameter int H_SYNC   = DEFAULT_TIMING.h_sync,
    parameter int H_BP     = DEFAULT_TIMING.h_bp,
    parameter int V_ACTIVE = DEFAULT_TIMING.v_active,
    parameter int V_FP     = DEFAULT_TIMING.v_fp,
    parameter int V_SYNC   = DEFAULT_TIMING.v_sync,
    parameter int V_BP     = DEFAULT_TIMING.v_bp
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ready,
    output logic [17:0] rd_addr,
    output logic        hsync_s1,
    output logic        vsync_s1,
    output logic        active_s1
);

    localparam logic [HC_W-1:0] H_ACT_END = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_START  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END    = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VC_W-1:0] V_ACT_END = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_START  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END    = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VC_W-1:0] V_LAST    = VC_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            h_last;
    logic            v_last;
    logic            in_active;
    logic            in_hsync;
    logic            in_vsync;
    logic            frame_start;

    always_comb begin
        h_last      = (hc == H_LAST);
        v_last      = (vc == V_LAST);
        in_active   = (hc < H_ACT_END) && (vc < V_ACT_END);
        in_hsync    = (hc >= HS_START) && (hc < HS_END);
        in_vsync    = (vc >= VS_START) && (vc < VS_END);
        frame_start = (hc == '0) && (vc == '0);
    end

    // NOTE: reset is synchronous, so it is simply the highest-priority branch of the
    // clocked block; non-blocking assignments keep every register reading pre-edge state.
    always_ff @(posedge clk) begin
        if (!reset_n || !ready) begin
            hc        <= '0;
            vc        <= '0;
            rd_addr   <= '0;
            hsync_s1  <= 1'b1;
            vsync_s1  <= 1'b1;
            active_s1 <= 1'b0;
        end else begin
            hc <= h_last ? '0 : hc + HC_W'(1);
            if (h_last) begin
                vc <= v_last ? '0 : vc + VC_W'(1);
            end
            // Address follows the raster incrementally and holds through blanking.
            if (frame_start) begin
                rd_addr <= '0;
            end else if (in_active) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
            hsync_s1  <= ~in_hsync;
            vsync_s1  <= ~in_vsync;
            active_s1 <= in_active;
        end
    end

endmodule

// File: rtl/display_driver.sv
// Raster timing generator and pixel formatter: delays syncs and the active flag to
// meet the frame-buffer read data, then maps colour indices through the palette.
module display_driver
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEFAULT_TIMING.h_active,
    parameter int H_FP     = DEFAULT_TIMING.h_fp,
    parameter int H_SYNC   = DEFAULT_TIMING.h_sync,
    parameter int H_BP     = DEFAULT_TIMING.h_bp,
    parameter int V_ACTIVE = DEFAULT_TIMING.v_active,
    parameter int V_FP     = DEFAULT_TIMING.v_fp,
    parameter int V_SYNC   = DEFAULT_TIMING.v_sync,
    parameter int V_BP     = DEFAULT_TIMING.v_bp
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ready,
    input  logic [3:0]  color,
    output logic [17:0] rd_addr,
    output logic        clock_out,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  y,
    output logic [2:0]  cr,
    output logic [2:0]  cb
);

    logic   hsync_s1;
    logic   vsync_s1;
    logic   active_s1;
    logic   hsync_s2;
    logic   vsync_s2;
    logic   active_s2;
    pixel_t pix_q;

    display_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset_n   (reset_n),
        .ready     (ready),
        .rd_addr   (rd_addr),
        .hsync_s1  (hsync_s1),
        .vsync_s1  (vsync_s1),
        .active_s1 (active_s1)
    );

    // The panel samples on the falling edge of clk, mid-way through each output pixel.
    assign clock_out = ~clk;

    // NOTE: reset clears the pixel to all-zero, while ready-low parks it at black (0,4,4);
    // the branch order encodes that priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hsync_s2  <= 1'b1;
            vsync_s2  <= 1'b1;
            active_s2 <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            pix_q     <= '0;
        end else if (!ready) begin
            hsync_s2  <= 1'b1;
            vsync_s2  <= 1'b1;
            active_s2 <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            pix_q     <= BLACK;
        end else begin
            hsync_s2  <= hsync_s1;
            vsync_s2  <= vsync_s1;
            active_s2 <= active_s1;
            hsync     <= hsync_s2;
            vsync     <= vsync_s2;
            pix_q     <= active_s2 ? PALETTE[color] : BLACK;
        end
    end

    assign y  = pix_q.y;
    assign cr = pix_q.cr;
    assign cb = pix_q.cb;

endmodule

// File: tb/tb_display_driver.sv
// Bench for display_driver: a full-size raster and a shrunken raster run side by side
// against a position-based reference model, plus targeted timing and palette checks.
module tb_display_driver;

    typedef struct packed {
        logic        rst;
        logic        act;
        logic        hs_n;
        logic        vs_n;
        logic [17:0] addr;
    } stage_t;

    localparam stage_t IDLE_ST = '{rst: 1'b0, act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, addr: 18'd0};
    localparam stage_t RST_ST  = '{rst: 1'b1, act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, addr: 18'd0};
    localparam logic [9:0] BLACK_REF = {4'd0, 3'd4, 3'd4};

    // Instance 0 uses the real 640x400 timing, instance 1 a tiny raster for whole frames.
    localparam int HA [2] = '{640, 20};
    localparam int HF [2] = '{16, 3};
    localparam int HS [2] = '{64, 5};
    localparam int HB [2] = '{80, 4};
    localparam int VA [2] = '{400, 5};
    localparam int VF [2] = '{4, 2};
    localparam int VS [2] = '{6, 3};
    localparam int VB [2] = '{40, 2};

    logic        clk;
    logic        reset_n;
    logic [1:0]  ready;
    logic [3:0]  color_i   [2];
    logic [17:0] rd_addr_o [2];
    logic [1:0]  clock_out_o;
    logic [1:0]  hsync_o;
    logic [1:0]  vsync_o;
    logic [3:0]  y_o       [2];
    logic [2:0]  cr_o      [2];
    logic [2:0]  cb_o      [2];

    int          checks;
    int          errors;
    logic        mon_en;
    int          fb_mode;
    logic [3:0]  fb_const;
    int          fb_seed;
    stage_t      hist [2][3];
    int          pos  [2];

    display_driver u_dut0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .ready     (ready[0]),
        .color     (color_i[0]),
        .rd_addr   (rd_addr_o[0]),
        .clock_out (clock_out_o[0]),
        .hsync     (hsync_o[0]),
        .vsync     (vsync_o[0]),
        .y         (y_o[0]),
        .cr        (cr_o[0]),
        .cb        (cb_o[0])
    );

    display_driver #(
        .H_ACTIVE (20), .H_FP (3), .H_SYNC (5), .H_BP (4),
        .V_ACTIVE (5),  .V_FP (2), .V_SYNC (3), .V_BP (2)
    ) u_dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .ready     (ready[1]),
        .color     (color_i[1]),
        .rd_addr   (rd_addr_o[1]),
        .clock_out (clock_out_o[1]),
        .hsync     (hsync_o[1]),
        .vsync     (vsync_o[1]),
        .y         (y_o[1]),
        .cr        (cr_o[1]),
        .cb        (cb_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Palette as {y, cb, cr}.
    function automatic logic [9:0] pal_ref(input logic [3:0] c);
        case (c)
            4'd0:    return {4'd0,  3'd4, 3'd4};
            4'd1:    return {4'd15, 3'd4, 3'd4};
            4'd2:    return {4'd5,  3'd3, 3'd7};
            4'd3:    return {4'd9,  3'd1, 3'd1};
            4'd4:    return {4'd2,  3'd7, 3'd3};
            default: return {c,     3'd4, 3'd4};
        endcase
    endfunction

    function automatic logic [3:0] fb_read(input logic [17:0] a);
        case (fb_mode)
            0:       return fb_const;
            1:       return a[3:0];
            default: return 4'(int'(a) * 5 + fb_seed);
        endcase
    endfunction

    function automatic int frame_len(input int i);
        return (HA[i] + HF[i] + HS[i] + HB[i]) * (VA[i] + VF[i] + VS[i] + VB[i]);
    endfunction

    // What the raster should present for counter position n within a frame.
    function automatic stage_t describe(input int i, input int n);
        int htot;
        int hc;
        int vc;
        int addr;
        stage_t s;
        htot   = HA[i] + HF[i] + HS[i] + HB[i];
        hc     = n % htot;
        vc     = n / htot;
        s.rst  = 1'b0;
        s.act  = (hc < HA[i]) && (vc < VA[i]);
        s.hs_n = !((hc >= HA[i] + HF[i]) && (hc < HA[i] + HF[i] + HS[i]));
        s.vs_n = !((vc >= VA[i] + VF[i]) && (vc < VA[i] + VF[i] + VS[i]));
        if (vc >= VA[i])      addr = VA[i] * HA[i] - 1;
        else if (hc >= HA[i]) addr = vc * HA[i] + HA[i] - 1;
        else                  addr = vc * HA[i] + hc;
        s.addr = 18'(addr);
        return s;
    endfunction

    function automatic logic [31:0] exp_vec(input int i);
        stage_t     o;
        logic [9:0] p;
        o = hist[i][2];
        if (o.rst)      p = '0;
        else if (o.act) p = pal_ref(fb_read(o.addr));
        else            p = BLACK_REF;
        return {1'b0, 1'b1, hist[i][0].addr, o.hs_n, o.vs_n, p[9:6], p[2:0], p[5:3]};
    endfunction

    function automatic logic [31:0] act_vec(input int i);
        return {1'b0, clock_out_o[i], rd_addr_o[i], hsync_o[i], vsync_o[i], y_o[i], cr_o[i], cb_o[i]};
    endfunction

    // Reference model: output is a 3-deep delay of the position description.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                hist[i][0] <= IDLE_ST;
                hist[i][1] <= IDLE_ST;
                hist[i][2] <= RST_ST;
                pos[i]     <= 0;
            end else if (!ready[i]) begin
                hist[i][0] <= IDLE_ST;
                hist[i][1] <= IDLE_ST;
                hist[i][2] <= IDLE_ST;
                pos[i]     <= 0;
            end else begin
                hist[i][0] <= describe(i, pos[i]);
                hist[i][1] <= hist[i][0];
                hist[i][2] <= hist[i][1];
                pos[i]     <= (pos[i] + 1) % frame_len(i);
            end
        end
    end

    // Synchronous frame-buffer: data one clock after the address.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            color_i[i] <= fb_read(rd_addr_o[i]);
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (errors < 40) check($sformatf("raster%0d", i), act_vec(i), exp_vec(i));
            end
        end
    end

    initial begin
        int cnt;
        int found;
        int hs_low;
        int vs_low;
        int act_cnt;
        int amax;
        checks   = 0;
        errors   = 0;
        mon_en   = 1'b0;
        reset_n  = 1'b0;
        ready    = 2'b11;
        fb_mode  = 1;
        fb_const = 4'd0;
        fb_seed  = 0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        check("rst_hsync",   32'(hsync_o[0]),   32'd1);
        check("rst_vsync",   32'(vsync_o[0]),   32'd1);
        check("rst_y",       32'(y_o[0]),       32'd0);
        check("rst_cr",      32'(cr_o[0]),      32'd0);
        check("rst_cb",      32'(cb_o[0]),      32'd0);
        check("rst_rd_addr", 32'(rd_addr_o[0]), 32'd0);
        reset_n = 1'b1;

        @(posedge clk); @(negedge clk);
        check("first_addr", 32'(rd_addr_o[0]), 32'd0);
        @(posedge clk); @(negedge clk);
        check("first_incr", 32'(rd_addr_o[0]), 32'd1);
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("palette%0d", k), 32'({y_o[0], cb_o[0], cr_o[0]}), 32'(pal_ref(4'(k))));
            @(posedge clk);
        end

        repeat (2000) @(posedge clk);
        @(negedge clk);
        ready = 2'b00;
        @(posedge clk); @(negedge clk);
        check("drop_addr0",  32'(rd_addr_o[0]), 32'd0);
        check("drop_hsync0", 32'(hsync_o[0]),   32'd1);
        check("drop_vsync0", 32'(vsync_o[0]),   32'd1);
        fb_mode  = 0;
        fb_const = 4'd3;
        repeat (998) @(posedge clk);
        @(negedge clk);
        check("idle_addr",  32'(rd_addr_o[0]), 32'd0);
        check("idle_hsync", 32'(hsync_o[0]),   32'd1);
        check("idle_vsync", 32'(vsync_o[0]),   32'd1);
        check("idle_black", 32'({y_o[0], cb_o[0], cr_o[0]}), 32'(BLACK_REF));

        ready = 2'b11;
        cnt   = 0;
        found = 0;
        while (found == 0 && cnt < 2000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (hsync_o[0] == 1'b0) found = 1;
        end
        check("hsync_fall_delay", 32'(cnt), 32'd659);

        hs_low  = 0;
        vs_low  = 0;
        act_cnt = 0;
        amax    = 0;
        repeat (frame_len(1)) begin
            @(posedge clk); @(negedge clk);
            if (!hsync_o[1]) hs_low++;
            if (!vsync_o[1]) vs_low++;
            if ({y_o[1], cb_o[1], cr_o[1]} == {4'd9, 3'd1, 3'd1}) act_cnt++;
            if (int'(rd_addr_o[1]) > amax) amax = int'(rd_addr_o[1]);
        end
        check("frame_hsync_low", 32'(hs_low),  32'(12 * 5));
        check("frame_vsync_low", 32'(vs_low),  32'(3 * 32));
        check("frame_active",    32'(act_cnt), 32'(20 * 5));
        check("frame_addr_max",  32'(amax),    32'(20 * 5 - 1));

        for (int r = 0; r < 8; r++) begin
            ready = 2'b00;
            @(posedge clk); @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("rdrop_addr%0d", i),  32'(rd_addr_o[i]), 32'd0);
                check($sformatf("rdrop_hsync%0d", i), 32'(hsync_o[i]),   32'd1);
                check($sformatf("rdrop_vsync%0d", i), 32'(vsync_o[i]),   32'd1);
            end
            fb_mode  = int'($urandom_range(0, 2));
            fb_const = 4'($urandom_range(0, 15));
            fb_seed  = int'($urandom_range(0, 1023));
            repeat ($urandom_range(0, 10)) @(posedge clk);
            @(negedge clk);
            ready = 2'b11;
            repeat ($urandom_range(200, 1600)) @(posedge clk);
            @(negedge clk);
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
